// File: rtl/uart_frame_parser.sv
// Deframer for SYNC/LEN/payload/CHK byte frames. Payload is released only after the checksum passes.
// Optional UART_FRAME_STATS_EN adds saturating ok_count/err_count outputs.
module uart_frame_parser #(
    parameter int unsigned MAX_PAYLOAD    = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned IdxW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned Depth   = 1 << IdxW;
    localparam logic [7:0]  MaxLen  = 8'(MAX_PAYLOAD);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StHunt, StLen, StPayload, StCheck, StEmit} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   len_m1_q, len_m1_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [7:0]        buf_q [Depth];
    logic              wr_en;
    logic              accept;
    logic              xfer;
    logic [7:0]        chk_sum;

    always_comb begin
        state_d  = state_q;
        len_m1_d = len_m1_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        wr_en    = 1'b0;

        in_ready  = ena && (state_q != StEmit);
        accept    = in_ready && in_valid;
        out_valid = (state_q == StEmit);
        out_data  = out_valid ? buf_q[rd_idx_q] : 8'h00;
        out_last  = out_valid && (rd_idx_q == len_m1_q);
        xfer      = out_valid && out_ready && ena;
        chk_sum   = sum_q + in_data;

        unique case (state_q)
            StHunt: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = StLen;
                    sum_d   = 8'h00;
                    tmo_d   = 32'd0;
                end
            end
            StLen: begin
                if (accept) begin
                    tmo_d = 32'd0;
                    if (in_data == 8'h00 || in_data > MaxLen) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = StHunt;
                    end else begin
                        len_m1_d = IdxW'(in_data - 8'd1);
                        sum_d    = in_data;
                        wr_idx_d = '0;
                        state_d  = StPayload;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    tmo_d    = 32'd0;
                    wr_en    = 1'b1;
                    sum_d    = chk_sum;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == len_m1_q) state_d = StCheck;
                end
            end
            StCheck: begin
                if (accept) begin
                    tmo_d = 32'd0;
                    if (chk_sum == 8'h00) begin
                        ok_d     = 1'b1;
                        rd_idx_d = '0;
                        state_d  = StEmit;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = StHunt;
                    end
                end
            end
            StEmit: begin
                if (xfer) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (out_last) state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        // Idle enabled cycles inside a frame count towards the abort.
        if (ena && !accept && (state_q == StLen || state_q == StPayload || state_q == StCheck)) begin
            if (tmo_q >= TmoLast) begin
                err_d   = 1'b1;
                code_d  = 2'd3;
                state_d = StHunt;
                tmo_d   = 32'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StHunt;
            len_m1_q <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            sum_q    <= 8'h00;
            tmo_q    <= 32'd0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            len_m1_q <= len_m1_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            sum_q    <= sum_d;
            tmo_q    <= tmo_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_idx_q] <= in_data;
    end

    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] ok_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (ok_d && ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
            if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ok_count  = ok_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser; each task drives one scenario and checks inline.
// Timeout shortened to 40 cycles to keep the run short.
module tb_uart_frame_parser;

    localparam int unsigned Tmo = 40;

    logic       clk = 1'b0;
    logic       reset, ena;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last, out_ready;
    logic       frame_ok, frame_err;
    logic [1:0] err_code;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] ok_count, err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [8:0] rx_q[$];
    int ok_seen, err_seen, both_seen;

    uart_frame_parser #(
        .MAX_PAYLOAD   (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
`ifdef UART_FRAME_STATS_EN
        ,
        .ok_count (ok_count),
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready && ena) rx_q.push_back({out_last, out_data});
        if (frame_ok) ok_seen++;
        if (frame_err) err_seen++;
        if (frame_ok && frame_err) both_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rx_q.delete();
        ok_seen  = 0;
        err_seen = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready got 0 expected 1 for byte %h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_rx(input string name, input int idx, input logic [8:0] exp);
        checks++;
        if (idx >= rx_q.size()) begin
            errors++;
            $display("FAIL %s[%0d]: got no byte expected %h", name, idx, exp);
        end else if (rx_q[idx] !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, rx_q[idx], exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_data, frame_ok, frame_err, err_code} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b l%b d%h ok%b err%b c%0d expected all zero",
                     out_valid, out_last, out_data, frame_ok, frame_err, err_code);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        clear();
        out_ready = 1'b1;
        foreach (f[i]) send(f[i]);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || frame_ok !== 1'b1) begin
            errors++;
            $display("FAIL good_latency: got v%b ok%b expected v1 ok1", out_valid, frame_ok);
        end
        tick();
        repeat (6) tick();
        check_rx("good_rx", 0, 9'h011);
        check_rx("good_rx", 1, 9'h022);
        check_rx("good_rx", 2, 9'h133);
        checks++;
        if (rx_q.size() != 3 || ok_seen != 1 || err_seen != 0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL good_summary: got n%0d ok%0d err%0d c%0d expected n3 ok1 err0 c0",
                     rx_q.size(), ok_seen, err_seen, err_code);
        end
    endtask

    task automatic test_garbage();
        logic [7:0] f[7] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h81};
        clear();
        foreach (f[i]) send(f[i]);
        repeat (5) tick();
        check_rx("garbage_rx", 0, 9'h17E);
        checks++;
        if (rx_q.size() != 1 || ok_seen != 1 || err_seen != 0) begin
            errors++;
            $display("FAIL garbage_summary: got n%0d ok%0d err%0d expected n1 ok1 err0",
                     rx_q.size(), ok_seen, err_seen);
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] f[5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        logic [7:0] g[4] = '{8'hA5, 8'h01, 8'h7E, 8'h81};
        clear();
        foreach (f[i]) send(f[i]);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd2 || out_valid !== 1'b0 || frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL badchk_pulse: got err%b c%0d v%b ok%b expected err1 c2 v0 ok0",
                     frame_err, err_code, out_valid, frame_ok);
        end
        tick();
        repeat (3) tick();
        checks++;
        if (rx_q.size() != 0 || err_seen != 1) begin
            errors++;
            $display("FAIL badchk_drop: got n%0d err%0d expected n0 err1", rx_q.size(), err_seen);
        end
        foreach (g[i]) send(g[i]);
        repeat (5) tick();
        check_rx("badchk_next", 0, 9'h17E);
        checks++;
        if (ok_seen != 1 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL badchk_recover: got ok%0d c%0d expected ok1 c2", ok_seen, err_code);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2] = '{8'h00, 8'h11};
        clear();
        foreach (lens[i]) begin
            send(8'hA5);
            send(lens[i]);
            @(negedge clk);
            checks++;
            if (frame_err !== 1'b1 || err_code !== 2'd1) begin
                errors++;
                $display("FAIL badlen_%h: got err%b c%0d expected err1 c1", lens[i], frame_err,
                         err_code);
            end
            tick();
        end
        // Next byte after the discard must be hunted, not taken as payload.
        send(8'h42);
        repeat (3) tick();
        checks++;
        if (err_seen != 2 || ok_seen != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL badlen_summary: got err%0d ok%0d n%0d expected err2 ok0 n0",
                     err_seen, ok_seen, rx_q.size());
        end
    endtask

    task automatic test_max_len();
        clear();
        send(8'hA5);
        send(8'h10);
        for (int i = 1; i <= 16; i++) send(8'(i));
        send(8'h68);
        repeat (20) tick();
        for (int i = 0; i < 16; i++) check_rx("maxlen_rx", i, {i == 15, 8'(i + 1)});
        checks++;
        if (rx_q.size() != 16 || ok_seen != 1 || err_code !== 2'd1) begin
            errors++;
            $display("FAIL maxlen_summary: got n%0d ok%0d c%0d expected n16 ok1 c1",
                     rx_q.size(), ok_seen, err_code);
        end
    endtask

    task automatic test_timeout();
        clear();
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        ena = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        ena = 1'b1;
        repeat (Tmo - 1) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || err_seen != 0) begin
            errors++;
            $display("FAIL timeout_early: got err%b seen%0d expected err0 seen0", frame_err,
                     err_seen);
        end
        tick();
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd3) begin
            errors++;
            $display("FAIL timeout_pulse: got err%b c%0d expected err1 c3", frame_err, err_code);
        end
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hunt: got rdy%b err%b expected rdy1 err0", in_ready, frame_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        int rdy_bad, stab_bad;
        logic prev_stall;
        logic [8:0] prev;
        rdy_bad = 0;
        stab_bad = 0;
        prev_stall = 1'b0;
        prev = '0;
        clear();
        out_ready = 1'b0;
        foreach (f[i]) send(f[i]);
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            @(negedge clk);
            if (out_valid) begin
                if (in_ready) rdy_bad++;
                if (prev_stall && {out_last, out_data} !== prev) stab_bad++;
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_last, out_data};
            tick();
        end
        out_ready = 1'b1;
        check_rx("bp_rx", 0, 9'h011);
        check_rx("bp_rx", 1, 9'h022);
        check_rx("bp_rx", 2, 9'h133);
        checks++;
        if (rdy_bad != 0 || stab_bad != 0 || rx_q.size() != 3 || ok_seen != 1) begin
            errors++;
            $display("FAIL bp_summary: got rdy_in_emit%0d unstable%0d n%0d ok%0d expected 0 0 3 1",
                     rdy_bad, stab_bad, rx_q.size(), ok_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        clear();
        for (int i = 0; i < 4; i++) send(f[i]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(8'h33);
        send(8'h97);
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_code !== 2'd0 || ok_seen != 0
            || err_seen != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL reset_midframe: got v%b rdy%b c%0d ok%0d err%0d n%0d expected 0 1 0 0 0 0",
                     out_valid, in_ready, err_code, ok_seen, err_seen, rx_q.size());
        end
        tick();
        out_ready = 1'b0;
        foreach (f[i]) send(f[i]);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL reset_midemit: got v%b d%h l%b n%0d expected v0 d00 l0 n0",
                     out_valid, out_data, out_last, rx_q.size());
        end
        tick();
        out_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        ena       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ok_seen   = 0;
        err_seen  = 0;
        both_seen = 0;
        #1;
        test_reset();
        test_good_frame();
        test_garbage();
        test_bad_chk();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (both_seen != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", both_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
